pwm_multi_duty: RTL and testbench

//  NCH-channel PWM generator sharing one period counter; each channel's duty is

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_duty_ctrl.sv | 66 ++++++
 rtl/pwm_multi_duty.sv | 60 ++++++
 tb/tb_pwm_multi_duty.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and duty arithmetic for the multi-channel PWM generator.
// sat_step works in int so the CW+1-bit intermediate never overflows.
package pwm_pkg;

  localparam int NCH_DEF         = 4;
  localparam int CW_DEF          = 8;
  localparam int PERIOD_DEF      = 50;
  localparam int STEP_DEF        = 5;
  localparam int DUTY_INIT_DEF   = 15;
  localparam int SYNC_STAGES_DEF = 2;

  // Next duty after one press, clamped to [0, period]; caller truncates to CW.
  function automatic int sat_step(input int pend, input logic up,
                                  input int step, input int period);
    int r;
    if (up) r = (pend + step > period) ? period : pend + step;
    else    r = (pend < step) ? 0 : pend - step;
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl.sv
// Per-channel duty control: button synchronisers, press detection, and the
// pending/active duty pair that keeps duty changes aligned to period wraps.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int PERIOD      = PERIOD_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int DUTY_INIT   = DUTY_INIT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          inc_n,
  input  logic          dec_n,
  input  logic          load,
  output logic [CW-1:0] duty_act
);

  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] dec_sync;
  logic                   inc_prev;
  logic                   dec_prev;
  logic                   inc_ev;
  logic                   dec_ev;
  logic [CW-1:0]          duty_pend;
  logic [CW-1:0]          pend_next;

  // Flops reset to 1 so a released button never looks like a fresh press.
  always_ff @(posedge clkin) begin
    if (reset) begin
      inc_sync <= '1;
      dec_sync <= '1;
      inc_prev <= 1'b1;
      dec_prev <= 1'b1;
    end else begin
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], inc_n};
      dec_sync <= {dec_sync[SYNC_STAGES-2:0], dec_n};
      inc_prev <= inc_sync[SYNC_STAGES-1];
      dec_prev <= dec_sync[SYNC_STAGES-1];
    end
  end

  assign inc_ev = inc_prev & ~inc_sync[SYNC_STAGES-1];
  assign dec_ev = dec_prev & ~dec_sync[SYNC_STAGES-1];

  always_comb begin
    pend_next = duty_pend;
    if (inc_ev && !dec_ev)
      pend_next = CW'(sat_step(int'(duty_pend), 1'b1, STEP, PERIOD));
    else if (dec_ev && !inc_ev)
      pend_next = CW'(sat_step(int'(duty_pend), 1'b0, STEP, PERIOD));
  end

  // The load samples the pre-event pend, so a press in the load cycle waits a period.
  always_ff @(posedge clkin) begin
    if (reset) begin
      duty_pend <= CW'(DUTY_INIT);
      duty_act  <= CW'(DUTY_INIT);
    end else begin
      duty_pend <= pend_next;
      if (load) duty_act <= duty_pend;
    end
  end

endmodule

// File: rtl/pwm_multi_duty.sv
// Multi-channel PWM: one shared period counter, per-channel duty controllers,
// and a compare stage that drives the PWM pins.
module pwm_multi_duty
  import pwm_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int CW          = CW_DEF,
  parameter int PERIOD      = PERIOD_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int DUTY_INIT   = DUTY_INIT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              en,
  input  logic [NCH-1:0]    inc_n,
  input  logic [NCH-1:0]    dec_n,
  output logic [NCH-1:0]    pwm,
  output logic [CW-1:0]     count,
  output logic              period_st,
  output logic [NCH*CW-1:0] duty
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          load;
  logic [CW-1:0] act [NCH];

  always_ff @(posedge clkin) begin
    if (reset)   cnt_q <= '0;
    else if (en) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign load      = en && (cnt_q == LAST);
  assign count     = cnt_q;
  assign period_st = en && (cnt_q == '0);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    pwm_duty_ctrl #(
      .CW          (CW),
      .PERIOD      (PERIOD),
      .STEP        (STEP),
      .DUTY_INIT   (DUTY_INIT),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ctrl (
      .clkin    (clkin),
      .reset    (reset),
      .inc_n    (inc_n[gi]),
      .dec_n    (dec_n[gi]),
      .load     (load),
      .duty_act (act[gi])
    );

    // duty == PERIOD gives count < duty on every count, i.e. a steady high.
    assign pwm[gi]             = en && (cnt_q < act[gi]);
    assign duty[gi*CW +: CW]   = act[gi];
  end

endmodule

// File: tb/tb_pwm_multi_duty.sv
// Self-checking bench for pwm_multi_duty: directed scenarios plus random
// button/enable/reset traffic against a cycle-level behavioural model.
module tb_pwm_multi_duty;

  localparam int NCH = 4;
  localparam int CW = 8;
  localparam int PERIOD = 50;
  localparam int STEP = 5;
  localparam int DUTY_INIT = 15;
  localparam int S = 2;
  localparam int W = NCH + CW + 1 + NCH * CW;

  logic              clkin = 1'b0;
  logic              reset_r = 1'b1;
  logic              en_r = 1'b1;
  logic [NCH-1:0]    inc_r = '1;
  logic [NCH-1:0]    dec_r = '1;
  logic [NCH-1:0]    pwm;
  logic [CW-1:0]     count;
  logic              period_st;
  logic [NCH*CW-1:0] duty;
  logic [W-1:0]      obs;

  int n_tests = 0;
  int n_fail = 0;

  // Model state: counter, pending/active duty, and each button's recent samples
  // (index 0 = sample taken at the most recent edge).
  int m_count;
  int m_pend [NCH];
  int m_act  [NCH];
  bit hi [NCH][S+1];
  bit hd [NCH][S+1];

  pwm_multi_duty #(
    .NCH(NCH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP),
    .DUTY_INIT(DUTY_INIT), .SYNC_STAGES(S)
  ) dut (
    .clkin     (clkin),
    .reset     (reset_r),
    .en        (en_r),
    .inc_n     (inc_r),
    .dec_n     (dec_r),
    .pwm       (pwm),
    .count     (count),
    .period_st (period_st),
    .duty      (duty)
  );

  always #5 clkin = ~clkin;

  assign obs = {pwm, count, period_st, duty};

  // A press registers S+1 edges after the button is first sampled low,
  // provided the sample before that was high.
  task automatic model_edge();
    bit ie, de, ld;
    if (reset_r) begin
      m_count = 0;
      for (int c = 0; c < NCH; c++) begin
        m_pend[c] = DUTY_INIT;
        m_act[c]  = DUTY_INIT;
        for (int k = 0; k <= S; k++) begin
          hi[c][k] = 1'b1;
          hd[c][k] = 1'b1;
        end
      end
    end else begin
      ld = en_r && (m_count == PERIOD - 1);
      for (int c = 0; c < NCH; c++) begin
        ie = !hi[c][S-1] && hi[c][S];
        de = !hd[c][S-1] && hd[c][S];
        if (ld) m_act[c] = m_pend[c];
        if (ie && !de)      m_pend[c] = (m_pend[c] + STEP > PERIOD) ? PERIOD : m_pend[c] + STEP;
        else if (de && !ie) m_pend[c] = (m_pend[c] < STEP) ? 0 : m_pend[c] - STEP;
        for (int k = S; k > 0; k--) begin
          hi[c][k] = hi[c][k-1];
          hd[c][k] = hd[c][k-1];
        end
        hi[c][0] = inc_r[c];
        hd[c][0] = dec_r[c];
      end
      if (en_r) m_count = (m_count + 1) % PERIOD;
    end
  endtask

  function automatic logic [W-1:0] exp_out();
    logic [NCH-1:0]    p;
    logic [NCH*CW-1:0] d;
    for (int c = 0; c < NCH; c++) begin
      p[c] = en_r && (m_count < m_act[c]);
      d[c*CW +: CW] = CW'(m_act[c]);
    end
    return {p, CW'(m_count), en_r && (m_count == 0), d};
  endfunction

  task automatic cyc();
    @(posedge clkin);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int ps;
    reset_r = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (duty !== {NCH{8'd15}}) begin n_fail++; $display("FAIL reset_duty got=%h exp=%h", duty, {NCH{8'd15}}); end
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    reset_r = 1'b0;
    ps = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL default_model got=%h exp=%h", obs, exp_out()); end
      n_tests++; if (pwm !== ((m_count < 15) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL default_pwm got=%b exp_high=%0d", pwm, m_count < 15); end
      if (period_st) ps++;
    end
    n_tests++; if (ps != 2) begin n_fail++; $display("FAIL period_st_pulses got=%0d exp=2", ps); end
  endtask

  task automatic test_inc();
    int hc;
    for (int k = 0; k < 100 && count !== 8'd20; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL inc_wait got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (count !== 8'd20) begin n_fail++; $display("FAIL inc_wait_count got=%0d exp=20", count); end
    inc_r[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL inc_press got=%h exp=%h", obs, exp_out()); end
    end
    inc_r[1] = 1'b1;
    n_tests++; if (duty[1*CW +: CW] !== 8'd15) begin n_fail++; $display("FAIL inc_before_wrap got=%0d exp=15", duty[1*CW +: CW]); end
    for (int k = 0; k < 60; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL inc_run got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (duty !== {8'd15, 8'd15, 8'd20, 8'd15}) begin n_fail++; $display("FAIL inc_duty got=%h exp=0f0f140f", duty); end
    hc = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL inc_period got=%h exp=%h", obs, exp_out()); end
      if (pwm[1]) hc++;
    end
    n_tests++; if (hc != 20) begin n_fail++; $display("FAIL inc_high_count got=%0d exp=20", hc); end
  endtask

  task automatic test_saturate();
    int hc;
    for (int p = 0; p < 22; p++) begin
      if (p < 11) dec_r[2] = 1'b0; else inc_r[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL sat_press got=%h exp=%h", obs, exp_out()); end
      end
      dec_r[2] = 1'b1;
      inc_r[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL sat_release got=%h exp=%h", obs, exp_out()); end
      end
      if (p == 10 || p == 21) begin
        for (int k = 0; k < 60; k++) begin
          cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL sat_settle got=%h exp=%h", obs, exp_out()); end
        end
        n_tests++; if (duty[2*CW +: CW] !== ((p == 10) ? 8'd0 : 8'd50)) begin n_fail++; $display("FAIL sat_duty got=%0d exp=%0d", duty[2*CW +: CW], (p == 10) ? 0 : 50); end
        hc = 0;
        for (int k = 0; k < PERIOD; k++) begin
          cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL sat_period got=%h exp=%h", obs, exp_out()); end
          if (pwm[2]) hc++;
        end
        n_tests++; if (hc != ((p == 10) ? 0 : PERIOD)) begin n_fail++; $display("FAIL sat_high_count got=%0d exp=%0d", hc, (p == 10) ? 0 : PERIOD); end
      end
    end
  endtask

  task automatic test_simultaneous();
    inc_r[3] = 1'b0;
    dec_r[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL both_press got=%h exp=%h", obs, exp_out()); end
    end
    inc_r[3] = 1'b1;
    dec_r[3] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL both_run got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (duty[3*CW +: CW] !== 8'd15) begin n_fail++; $display("FAIL both_duty got=%0d exp=15", duty[3*CW +: CW]); end
    inc_r[0] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL hold_press got=%h exp=%h", obs, exp_out()); end
    end
    inc_r[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL hold_run got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (duty[0 +: CW] !== 8'd20) begin n_fail++; $display("FAIL hold_duty got=%0d exp=20", duty[0 +: CW]); end
  endtask

  task automatic test_load_edge();
    int hc;
    for (int k = 0; k < 100 && count !== 8'(PERIOD - 1 - S); k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL edge_wait got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (count !== 8'(PERIOD - 1 - S)) begin n_fail++; $display("FAIL edge_wait_count got=%0d exp=%0d", count, PERIOD - 1 - S); end
    inc_r[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL edge_press got=%h exp=%h", obs, exp_out()); end
    end
    inc_r[3] = 1'b1;
    n_tests++; if (count !== 8'd0 || duty[3*CW +: CW] !== 8'd15) begin n_fail++; $display("FAIL edge_first_wrap got count=%0d duty=%0d exp count=0 duty=15", count, duty[3*CW +: CW]); end
    hc = pwm[3] ? 1 : 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL edge_period got=%h exp=%h", obs, exp_out()); end
      if (k < PERIOD - 1 && pwm[3]) hc++;
    end
    n_tests++; if (hc != 15) begin n_fail++; $display("FAIL edge_old_high_count got=%0d exp=15", hc); end
    n_tests++; if (duty[3*CW +: CW] !== 8'd20) begin n_fail++; $display("FAIL edge_second_wrap got=%0d exp=20", duty[3*CW +: CW]); end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] held;
    for (int k = 0; k < 100 && count !== 8'd30; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL mid_wait got=%h exp=%h", obs, exp_out()); end
    end
    n_tests++; if (count !== 8'd30) begin n_fail++; $display("FAIL mid_wait_count got=%0d exp=30", count); end
    reset_r = 1'b1;
    cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL mid_reset got=%h exp=%h", obs, exp_out()); end
    n_tests++; if (count !== 8'd0 || duty !== {NCH{8'd15}}) begin n_fail++; $display("FAIL mid_reset_state got count=%0d duty=%h exp count=0 duty=0f0f0f0f", count, duty); end
    reset_r = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL mid_run got=%h exp=%h", obs, exp_out()); end
    end
    en_r = 1'b0;
    held = 8'd20;
    for (int k = 0; k < 10; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL en_off got=%h exp=%h", obs, exp_out()); end
      n_tests++; if (pwm !== 4'h0 || count !== held) begin n_fail++; $display("FAIL en_off_hold got pwm=%b count=%0d exp pwm=0000 count=%0d", pwm, count, held); end
    end
    en_r = 1'b1;
    cyc(); n_tests++; if (count !== held + 8'd1) begin n_fail++; $display("FAIL en_resume got=%0d exp=%0d", count, held + 8'd1); end
    for (int k = 0; k < 10; k++) begin
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL en_on got=%h exp=%h", obs, exp_out()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset_r = ($urandom_range(499) == 0);
      if ($urandom_range(49) == 0) en_r = ~en_r;
      if ($urandom_range(7) == 0) inc_r[$urandom_range(NCH-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) dec_r[$urandom_range(NCH-1)] ^= 1'b1;
      cyc(); n_tests++; if (obs !== exp_out()) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", k, obs, exp_out()); end
    end
    reset_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inc();
    test_saturate();
    test_simultaneous();
    test_load_edge();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
